// File: rtl/freq_meter.sv
// freq_meter: counts rising edges and high cycles of an asynchronous input
// over a fixed gate window of GATE_CYCLES clocks. Results are published
// together with a one-cycle FREQ_VALID strobe after each complete window.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 96000000,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned GATE_WIDTH  = 27
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  SIG_IN,
  input  logic                  ENABLE,
  output logic [CNT_WIDTH-1:0]  FREQ,
  output logic [GATE_WIDTH-1:0] HIGH_CNT,
  output logic                  OVERFLOW,
  output logic                  FREQ_VALID,
  output logic                  GATE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [GATE_WIDTH-1:0] LP_LAST = GATE_WIDTH'(GATE_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_s1, r_s2, r_s3;
  logic                  w_rise;
  logic                  w_last;
  logic                  w_run_on;
  logic                  w_edge_sat;
  logic [GATE_WIDTH-1:0] r_gate_cnt;
  logic [GATE_WIDTH-1:0] r_high_cnt;
  logic [GATE_WIDTH-1:0] w_high_nxt;
  logic [CNT_WIDTH-1:0]  r_edge_cnt;
  logic [CNT_WIDTH-1:0]  w_edge_nxt;
  logic                  r_ovf;
  logic                  w_ovf_nxt;
  logic [CNT_WIDTH-1:0]  r_tot_edge;
  logic [GATE_WIDTH-1:0] r_tot_high;
  logic                  r_tot_ovf;
  logic                  r_pend;

  assign GATE = (r_state == RUN);

  // Synchronize SIG_IN and keep one history flop for edge detection
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= SIG_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next-state logic and next values of the window accumulators
  always_comb begin
    w_state_nxt = r_state;
    w_rise      = r_s2 & ~r_s3;
    w_last      = (r_state == RUN) && (r_gate_cnt == LP_LAST);
    w_run_on    = (r_state == RUN) && ENABLE && !w_last;
    w_edge_sat  = &r_edge_cnt;
    w_edge_nxt  = r_edge_cnt + CNT_WIDTH'(w_rise & ~w_edge_sat);
    w_ovf_nxt   = r_ovf | (w_rise & w_edge_sat);
    w_high_nxt  = r_high_cnt + GATE_WIDTH'(r_s2);
    case (r_state)
      IDLE: if (ENABLE) w_state_nxt = RUN;
      RUN:  if (!ENABLE && !w_last) w_state_nxt = IDLE;
            else if (w_last && !ENABLE) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Window counters: run while gated, clear on idle, abort or window end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_high_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (w_run_on) begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
      r_edge_cnt <= w_edge_nxt;
      r_high_cnt <= w_high_nxt;
      r_ovf      <= w_ovf_nxt;
    end else begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_high_cnt <= '0;
      r_ovf      <= 1'b0;
    end
  end

  // Totals are staged for one cycle so outputs and strobe update together
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tot_edge <= '0;
      r_tot_high <= '0;
      r_tot_ovf  <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_pend <= w_last;
      if (w_last) begin
        r_tot_edge <= w_edge_nxt;
        r_tot_high <= w_high_nxt;
        r_tot_ovf  <= w_ovf_nxt;
      end
    end
  end

  // Publish results with the FREQ_VALID strobe
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FREQ       <= '0;
      HIGH_CNT   <= '0;
      OVERFLOW   <= 1'b0;
      FREQ_VALID <= 1'b0;
    end else begin
      FREQ_VALID <= r_pend;
      if (r_pend) begin
        FREQ     <= r_tot_edge;
        HIGH_CNT <= r_tot_high;
        OVERFLOW <= r_tot_ovf;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter with a scoreboard queue of
// expected window results per instance.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig = 1'b0;
  logic        en1, en2;
  logic [23:0] f1;
  logic [10:0] h1;
  logic        o1, v1, g1;
  logic [5:0]  f2;
  logic [10:0] h2;
  logic        o2, v2, g2;

  freq_meter #(.GATE_CYCLES(1000), .CNT_WIDTH(24), .GATE_WIDTH(11)) u_dut1 (
    .CLK(clk), .RESET_N(rst_n), .SIG_IN(sig), .ENABLE(en1),
    .FREQ(f1), .HIGH_CNT(h1), .OVERFLOW(o1), .FREQ_VALID(v1), .GATE(g1)
  );

  freq_meter #(.GATE_CYCLES(1000), .CNT_WIDTH(6), .GATE_WIDTH(11)) u_dut2 (
    .CLK(clk), .RESET_N(rst_n), .SIG_IN(sig), .ENABLE(en2),
    .FREQ(f2), .HIGH_CNT(h2), .OVERFLOW(o2), .FREQ_VALID(v2), .GATE(g2)
  );

  always #5 clk = ~clk;

  // Signal generator: square wave or constant level, changes 2 units after posedge
  bit   gen_sq     = 1'b0;
  int   gen_period = 8;
  int   gen_high   = 4;
  int   phase      = 0;
  logic gen_const  = 1'b0;

  always @(posedge clk) begin
    #2;
    if (gen_sq) begin
      if (phase + 1 >= gen_period) phase = 0;
      else phase = phase + 1;
      sig = (phase < gen_high);
    end else begin
      sig = gen_const;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string tag;
    bit    skip;
    int    f;
    int    h;
    bit    ovf;
    int    htol;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  function automatic exp_t mk(string tag, bit skip, int f, int h, bit ovf, int htol);
    exp_t e;
    e.tag = tag; e.skip = skip; e.f = f; e.h = h; e.ovf = ovf; e.htol = htol;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                         input int tol);
    n_total++;
    assert ((obs + tol >= exp) && (obs <= exp + tol)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
  endtask

  // Wait for a strobe from instance `which`, then pop and compare its expectation
  task automatic wait_check(input int which, input int budget, output int cyc);
    logic v;
    exp_t e;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      v = (which == 1) ? v1 : v2;
    end while (!v && cyc < budget);
    if (!v) begin
      chk("valid_timeout", {31'd0, v}, 32'd1);
    end else if (which == 1) begin
      chk("sb1_nonempty", q1.size(), (q1.size() == 0) ? 32'd1 : q1.size());
      if (q1.size() != 0) begin
        e = q1.pop_front();
        if (!e.skip) begin
          chk($sformatf("%s_freq", e.tag), f1, e.f);
          chk_tol($sformatf("%s_high", e.tag), h1, e.h, e.htol);
          chk($sformatf("%s_ovf", e.tag), o1, e.ovf);
        end
      end
    end else begin
      chk("sb2_nonempty", q2.size(), (q2.size() == 0) ? 32'd1 : q2.size());
      if (q2.size() != 0) begin
        e = q2.pop_front();
        if (!e.skip) begin
          chk($sformatf("%s_freq", e.tag), f2, e.f);
          chk_tol($sformatf("%s_high", e.tag), h2, e.h, e.htol);
          chk($sformatf("%s_ovf", e.tag), o2, e.ovf);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit saw;
    rst_n = 1'b0;
    en1   = 1'b1;
    en2   = 1'b0;

    // Reset with ENABLE held high
    repeat (3) @(negedge clk);
    chk("rst_freq", f1, 0);
    chk("rst_high", h1, 0);
    chk("rst_ovf", o1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_gate", g1, 0);
    rst_n = 1'b1;
    #1 chk("gate_pre", g1, 0);
    @(negedge clk);
    chk("gate_rise", g1, 1);

    // Constant low input: first latency and strobe period
    q1.push_back(mk("zero1", 0, 0, 0, 0, 0));
    wait_check(1, 1100, cyc);
    chk("first_latency", cyc, 1001);
    q1.push_back(mk("zero2", 0, 0, 0, 0, 0));
    wait_check(1, 1100, cyc);
    chk("strobe_period", cyc, 1000);

    // Square wave, period 8
    gen_period = 8; gen_high = 4; gen_sq = 1'b1;
    q1.push_back(mk("sq8_partial", 1, 0, 0, 0, 0));
    q1.push_back(mk("sq8_a", 0, 125, 500, 0, 0));
    q1.push_back(mk("sq8_b", 0, 125, 500, 0, 0));
    repeat (3) wait_check(1, 1100, cyc);
    chk("sq8_period", cyc, 1000);

    // Constant high input
    gen_sq = 1'b0; gen_const = 1'b1;
    q1.push_back(mk("hi_partial", 1, 0, 0, 0, 0));
    q1.push_back(mk("hi_a", 0, 0, 1000, 0, 0));
    q1.push_back(mk("hi_b", 0, 0, 1000, 0, 0));
    repeat (3) wait_check(1, 1100, cyc);

    // Duty 3/10
    gen_period = 10; gen_high = 3; gen_sq = 1'b1;
    q1.push_back(mk("duty_partial", 1, 0, 0, 0, 0));
    q1.push_back(mk("duty_a", 0, 100, 300, 0, 3));
    q1.push_back(mk("duty_b", 0, 100, 300, 0, 3));
    repeat (3) wait_check(1, 1100, cyc);

    // Abort at gate count 500 (now in cycle 1 of the new window)
    repeat (499) @(negedge clk);
    chk("abort_gate_before", g1, 1);
    en1 = 1'b0;
    @(negedge clk);
    chk("abort_gate_after", g1, 0);
    saw = 1'b0;
    repeat (1200) begin
      @(negedge clk);
      if (v1) saw = 1'b1;
    end
    chk("abort_no_valid", {31'd0, saw}, 0);
    chk("abort_hold_freq", f1, 100);
    chk_tol("abort_hold_high", h1, 300, 3);

    // Re-enable: fresh full window
    en1 = 1'b1;
    @(negedge clk);
    chk("reen_gate", g1, 1);
    q1.push_back(mk("reen", 0, 100, 300, 0, 3));
    wait_check(1, 1100, cyc);
    chk("reen_latency", cyc, 1001);

    // Reset asserted mid-window clears outputs immediately
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_freq", f1, 0);
    chk("midrst_high", h1, 0);
    chk("midrst_ovf", o1, 0);
    chk("midrst_valid", v1, 0);
    chk("midrst_gate", g1, 0);

    // Boundary: edge detected exactly on gate count 999
    gen_sq = 1'b0; gen_const = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("bnd_gate", g1, 1);
    repeat (996) @(negedge clk);
    gen_const = 1'b1;
    q1.push_back(mk("edge999", 0, 1, 1, 0, 0));
    q1.push_back(mk("after999", 0, 0, 1000, 0, 0));
    wait_check(1, 1100, cyc);
    wait_check(1, 1100, cyc);
    chk("after999_period", cyc, 1000);

    // Overflow on the 6-bit instance
    en1 = 1'b0;
    gen_period = 4; gen_high = 2; gen_sq = 1'b1;
    repeat (5) @(negedge clk);
    en2 = 1'b1;
    q2.push_back(mk("ovf_sat", 0, 63, 500, 1, 0));
    wait_check(2, 1200, cyc);
    gen_period = 40; gen_high = 20;
    q2.push_back(mk("ovf_partial", 1, 0, 0, 0, 0));
    q2.push_back(mk("ovf_clear", 0, 25, 500, 0, 0));
    wait_check(2, 1100, cyc);
    wait_check(2, 1100, cyc);
    chk("ovf_period", cyc, 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
